// File: rtl/pool5_arith_pkg.sv
// Shared arithmetic helpers for the pool5 datapath: product width and result
// width mapping (truncate or zero/sign-extend).
package pool5_arith_pkg;

    localparam int unsigned MIN_NUM_STAGE = 1;
    // Widest result the width-mapping helper can produce.
    localparam int unsigned MAX_WIDTH     = 64;

    function automatic int unsigned prod_width(input int unsigned a, input int unsigned b);
        return a + b;
    endfunction

    // Extends a pw-bit product to MAX_WIDTH bits; callers keep the low bits they need.
    function automatic logic [MAX_WIDTH-1:0] fit_product(input logic [MAX_WIDTH-1:0] prod,
                                                         input int unsigned         pw,
                                                         input bit                  sgn);
        logic [MAX_WIDTH-1:0] res;
        res = prod;
        for (int unsigned i = 0; i < MAX_WIDTH; i++) begin
            if (i >= pw) begin
                res[i] = sgn & prod[pw-1];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/pool5_mul_pipe_stage.sv
// One pipeline register stage carrying {valid, tag, data}; data and tag load
// only on an enabled cycle with a valid incoming beat.
module pool5_mul_pipe_stage #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             ap_clk,
    input  logic             ap_rst,
    input  logic             ce,
    input  logic             in_valid,
    input  logic             in_tag,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic             out_tag,
    output logic [WIDTH-1:0] out_data
);

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            out_valid <= 1'b0;
            out_tag   <= 1'b0;
            out_data  <= '0;
        end else if (ce) begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_tag  <= in_tag;
                out_data <= in_data;
            end
        end
    end

endmodule

// File: rtl/pool5_mul_pipe.sv
// Pipelined multiplier for the pool5 kernel: configurable widths, signed mode,
// NUM_STAGE-deep valid-tracked pipeline with clock enable, optional accumulator.
module pool5_mul_pipe
    import pool5_arith_pkg::*;
#(
    parameter int unsigned DIN0_WIDTH = 3,
    parameter int unsigned DIN1_WIDTH = 6,
    parameter int unsigned DOUT_WIDTH = 8,
    parameter int unsigned NUM_STAGE  = 2,
    parameter int unsigned SIGNED     = 0,
    parameter int unsigned ACC_EN     = 0
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic                  ce,
    input  logic                  in_valid,
    input  logic [DIN0_WIDTH-1:0] din0,
    input  logic [DIN1_WIDTH-1:0] din1,
    input  logic                  acc_clr,
    output logic                  out_valid,
    output logic [DOUT_WIDTH-1:0] dout
);

    localparam int unsigned P    = prod_width(DIN0_WIDTH, DIN1_WIDTH);
    localparam int unsigned LAST = NUM_STAGE - 1;

    if (NUM_STAGE < MIN_NUM_STAGE) begin : g_bad_num_stage
        $error("pool5_mul_pipe: NUM_STAGE must be at least 1");
    end

    logic [P-1:0]          prod_u;
    logic signed [P-1:0]   op0_s, op1_s, prod_s;
    logic [P-1:0]          prod_raw;
    logic [DOUT_WIDTH-1:0] prod_fit;

    // Operands widened to the full product width so the P-bit product is exact.
    assign prod_u   = P'(din0) * P'(din1);
    assign op0_s    = {{(P-DIN0_WIDTH){din0[DIN0_WIDTH-1]}}, din0};
    assign op1_s    = {{(P-DIN1_WIDTH){din1[DIN1_WIDTH-1]}}, din1};
    assign prod_s   = op0_s * op1_s;
    assign prod_raw = (SIGNED != 0) ? prod_s : prod_u;
    assign prod_fit = DOUT_WIDTH'(fit_product(MAX_WIDTH'(prod_raw), P, SIGNED != 0));

    logic                  st_valid [NUM_STAGE];
    logic                  st_tag   [NUM_STAGE];
    logic [DOUT_WIDTH-1:0] st_data  [NUM_STAGE];

    logic                  s1_valid_q, s1_tag_q;
    logic [DOUT_WIDTH-1:0] s1_data_q;

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            s1_valid_q <= 1'b0;
            s1_tag_q   <= 1'b0;
            s1_data_q  <= '0;
        end else if (ce) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_tag_q  <= acc_clr;
                s1_data_q <= prod_fit;
            end
        end
    end

    assign st_valid[0] = s1_valid_q;
    assign st_tag[0]   = s1_tag_q;
    assign st_data[0]  = s1_data_q;

    for (genvar k = 1; k < NUM_STAGE; k++) begin : g_delay
        pool5_mul_pipe_stage #(
            .WIDTH(DOUT_WIDTH)
        ) u_stage (
            .ap_clk   (ap_clk),
            .ap_rst   (ap_rst),
            .ce       (ce),
            .in_valid (st_valid[k-1]),
            .in_tag   (st_tag[k-1]),
            .in_data  (st_data[k-1]),
            .out_valid(st_valid[k]),
            .out_tag  (st_tag[k]),
            .out_data (st_data[k])
        );
    end

    if (ACC_EN != 0) begin : g_acc
        logic                  acc_valid_q;
        logic [DOUT_WIDTH-1:0] acc_q;

        // Sum wraps modulo 2^DOUT_WIDTH; a tagged beat restarts the running total.
        always_ff @(posedge ap_clk) begin
            if (ap_rst) begin
                acc_valid_q <= 1'b0;
                acc_q       <= '0;
            end else if (ce) begin
                acc_valid_q <= st_valid[LAST];
                if (st_valid[LAST]) begin
                    acc_q <= st_tag[LAST] ? st_data[LAST] : acc_q + st_data[LAST];
                end
            end
        end

        assign out_valid = acc_valid_q;
        assign dout      = acc_q;
    end else begin : g_no_acc
        logic unused_tag;
        assign unused_tag = st_tag[LAST];
        assign out_valid  = st_valid[LAST];
        assign dout       = st_data[LAST];
    end

endmodule

// File: tb/tb_pool5_mul_pipe.sv
// Self-checking bench: table vectors, hand sequences for signed/accumulate, and
// random traffic against a beat-history reference model for three configurations.
module tb_pool5_mul_pipe;

    logic       clk = 1'b0;
    logic       rst, ce, iv, clr;
    logic [2:0] a;
    logic [5:0] b;
    logic       ov_p, ov_s, ov_a;
    logic [7:0] do_p, do_s, do_a;

    always #5 clk = ~clk;

    pool5_mul_pipe u_plain (
        .ap_clk(clk), .ap_rst(rst), .ce(ce), .in_valid(iv), .din0(a), .din1(b),
        .acc_clr(clr), .out_valid(ov_p), .dout(do_p)
    );

    pool5_mul_pipe #(.SIGNED(1)) u_signed (
        .ap_clk(clk), .ap_rst(rst), .ce(ce), .in_valid(iv), .din0(a), .din1(b),
        .acc_clr(clr), .out_valid(ov_s), .dout(do_s)
    );

    pool5_mul_pipe #(.ACC_EN(1)) u_acc (
        .ap_clk(clk), .ap_rst(rst), .ce(ce), .in_valid(iv), .din0(a), .din1(b),
        .acc_clr(clr), .out_valid(ov_a), .dout(do_a)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference model: history of beats accepted on enabled cycles; a beat
    // emerges after its configuration's latency counted in enabled cycles.
    int hv[16], ha[16], hb[16], hc[16];
    int e = 100;
    int lat[3] = '{2, 2, 3};
    int m_ov[3], m_do[3], m_acc[3];

    function automatic int ref_prod(input int d, input int x, input int y);
        int sx, sy;
        if (d == 1) begin
            sx = (x >= 4) ? x - 8 : x;
            sy = (y >= 32) ? y - 64 : y;
            return (sx * sy) & 255;
        end
        return (x * y) & 255;
    endfunction

    task automatic step(input int r, input int c, input int v, input int x, input int y,
                        input int t);
        int idx, p;
        rst = (r != 0); ce = (c != 0); iv = (v != 0); clr = (t != 0);
        a = x[2:0]; b = y[5:0];
        @(posedge clk);
        if (r != 0) begin
            for (int i = 0; i < 16; i++) hv[i] = 0;
            for (int d = 0; d < 3; d++) begin
                m_ov[d] = 0; m_do[d] = 0; m_acc[d] = 0;
            end
        end else if (c != 0) begin
            e++;
            hv[e & 15] = v; ha[e & 15] = x & 7; hb[e & 15] = y & 63; hc[e & 15] = t;
            for (int d = 0; d < 3; d++) begin
                idx = (e - lat[d] + 1) & 15;
                if (hv[idx] != 0) begin
                    p = ref_prod(d, ha[idx], hb[idx]);
                    if (d == 2) begin
                        m_acc[d] = (hc[idx] != 0) ? p : (m_acc[d] + p) & 255;
                        m_do[d]  = m_acc[d];
                    end else begin
                        m_do[d] = p;
                    end
                    m_ov[d] = 1;
                end else begin
                    m_ov[d] = 0;
                end
            end
        end
        #1;
        check("plain_valid",  32'(ov_p), m_ov[0]);
        check("plain_dout",   32'(do_p), m_do[0]);
        check("signed_valid", 32'(ov_s), m_ov[1]);
        check("signed_dout",  32'(do_s), m_do[1]);
        check("acc_valid",    32'(ov_a), m_ov[2]);
        check("acc_dout",     32'(do_a), m_do[2]);
    endtask

    typedef struct {
        int rst; int ce; int iv; int a; int b; int clr; int eov; int edo;
    } vec_t;

    vec_t vec[29];
    int   acc_seen[$];
    int   first_idx;

    initial begin
        for (int i = 0; i < 16; i++) hv[i] = 0;
        rst = 1'b1; ce = 1'b0; iv = 1'b0; clr = 1'b0; a = '0; b = '0;

        // rst ce iv a b clr | expected out_valid, dout of the default configuration
        vec[0]  = '{1, 1, 0, 0, 0,  0, 0, 0};
        vec[1]  = '{0, 1, 1, 7, 63, 0, 0, 0};
        vec[2]  = '{0, 1, 0, 0, 0,  0, 1, 185};
        vec[3]  = '{0, 1, 0, 0, 0,  0, 0, 185};
        vec[4]  = '{0, 1, 1, 1, 2,  0, 0, 185};
        vec[5]  = '{0, 1, 1, 3, 4,  0, 1, 2};
        vec[6]  = '{0, 1, 1, 5, 6,  0, 1, 12};
        vec[7]  = '{0, 1, 0, 0, 0,  0, 1, 30};
        vec[8]  = '{0, 1, 0, 0, 0,  0, 0, 30};
        vec[9]  = '{0, 1, 1, 2, 10, 0, 0, 30};
        vec[10] = '{0, 0, 0, 0, 0,  0, 0, 30};
        vec[11] = '{0, 0, 1, 7, 7,  0, 0, 30};
        vec[12] = '{0, 0, 0, 0, 0,  0, 0, 30};
        vec[13] = '{0, 1, 0, 0, 0,  0, 1, 20};
        vec[14] = '{0, 1, 0, 0, 0,  0, 0, 20};
        vec[15] = '{0, 1, 1, 3, 3,  0, 0, 20};
        vec[16] = '{0, 1, 0, 0, 0,  0, 1, 9};
        vec[17] = '{0, 0, 0, 0, 0,  0, 1, 9};
        vec[18] = '{0, 0, 1, 4, 4,  0, 1, 9};
        vec[19] = '{0, 1, 0, 0, 0,  0, 0, 9};
        vec[20] = '{0, 1, 1, 5, 5,  0, 0, 9};
        vec[21] = '{1, 1, 0, 0, 0,  0, 0, 0};
        vec[22] = '{0, 1, 0, 0, 0,  0, 0, 0};
        vec[23] = '{0, 1, 0, 0, 0,  0, 0, 0};
        vec[24] = '{0, 1, 1, 1, 3,  0, 0, 0};
        vec[25] = '{0, 1, 1, 6, 6,  0, 1, 3};
        vec[26] = '{1, 0, 0, 0, 0,  0, 0, 0};
        vec[27] = '{0, 1, 0, 0, 0,  0, 0, 0};
        vec[28] = '{0, 1, 0, 0, 0,  0, 0, 0};

        for (int i = 0; i < 29; i++) begin
            step(vec[i].rst, vec[i].ce, vec[i].iv, vec[i].a, vec[i].b, vec[i].clr);
            check($sformatf("tbl%0d_valid", i), 32'(ov_p), vec[i].eov);
            check($sformatf("tbl%0d_dout", i), 32'(do_p), vec[i].edo);
        end

        // Signed mode: -1*5 and -4*-32.
        step(1, 1, 0, 0, 0, 0);
        step(0, 1, 1, 7, 5, 0);
        step(0, 1, 1, 4, 32, 0);
        check("signed_neg_valid", 32'(ov_s), 1);
        check("signed_neg_dout",  32'(do_s), 251);
        step(0, 1, 0, 0, 0, 0);
        check("signed_pos_valid", 32'(ov_s), 1);
        check("signed_pos_dout",  32'(do_s), 128);

        // Accumulate: bounded collection of accumulator results.
        step(1, 1, 0, 0, 0, 0);
        first_idx = -1;
        for (int i = 0; i < 10; i++) begin
            case (i)
                0: step(0, 1, 1, 2, 3, 1);
                1: step(0, 1, 1, 1, 4, 0);
                2: step(0, 1, 1, 7, 63, 0);
                3: step(0, 1, 1, 1, 1, 1);
                default: step(0, 1, 0, 0, 0, 0);
            endcase
            if (ov_a) begin
                if (first_idx < 0) first_idx = i;
                acc_seen.push_back(int'(do_a));
            end
        end
        check("acc_latency", first_idx, 2);
        check("acc_count", acc_seen.size(), 4);
        if (acc_seen.size() == 4) begin
            check("acc_r0", acc_seen[0], 6);
            check("acc_r1", acc_seen[1], 10);
            check("acc_r2", acc_seen[2], 195);
            check("acc_r3", acc_seen[3], 1);
        end

        // Random traffic with stalls, bubbles, occasional resets.
        step(1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 63) == 0) ? 1 : 0,
                 ($urandom_range(0, 7) != 0) ? 1 : 0,
                 ($urandom_range(0, 3) != 0) ? 1 : 0,
                 int'($urandom_range(0, 7)), int'($urandom_range(0, 63)),
                 ($urandom_range(0, 3) == 0) ? 1 : 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
